// File: rtl/ultra_trigger_if.sv
// Sensor-facing bundle for the ultrasonic ranging controller.
// The slave view belongs to ultra_trigger; the master view drives enable/echo and observes results.
interface ultra_trigger_if;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [19:0] contador2;
  logic        dato_valido;
  logic        timeout;
  logic        busy;

  modport master (
    output enable, echo,
    input  trig, contador2, dato_valido, timeout, busy
  );

  modport slave (
    input  enable, echo,
    output trig, contador2, dato_valido, timeout, busy
  );
endinterface

// File: rtl/ultra_trigger.sv
// Periodic ultrasonic trigger generator and echo-width meter.
// Fires a TRIG_CYCLES pulse every PERIOD cycles and reports echo width or a timeout code.
module ultra_trigger #(
  parameter int unsigned TRIG_CYCLES = 500,
  parameter int unsigned ECHO_WAIT   = 50000,
  parameter int unsigned ECHO_MAX    = 1000000,
  parameter int unsigned PERIOD      = 3000000
) (
  input  logic           clk,
  input  logic           rst,
  ultra_trigger_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam logic [21:0] TRIG_LAST = 22'(TRIG_CYCLES - 1);
  localparam logic [21:0] PER_LAST  = 22'(PERIOD - 1);
  localparam logic [19:0] WAIT_LAST = 20'(ECHO_WAIT - 1);
  localparam logic [19:0] CNT_MAX   = 20'(ECHO_MAX);
  localparam logic [19:0] NO_ECHO   = '1;

  state_e      state_q, state_d;
  logic [21:0] per_q, per_d;
  logic [19:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [19:0] res_q, res_d;
  logic        to_q, to_d;
  logic        dv_q, dv_d;
  logic        echo_meta_q, echo_s_q;
  logic        echo_s;

  assign echo_s = echo_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      per_q       <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      res_q       <= '0;
      to_q        <= 1'b0;
      dv_q        <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      res_q       <= res_d;
      to_q        <= to_d;
      dv_q        <= dv_d;
      echo_meta_q <= bus.echo;
      echo_s_q    <= echo_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    res_d   = res_q;
    to_d    = to_q;
    dv_d    = 1'b0;

    // Period counter runs from trig rise through HOLDOFF so shots are spaced exactly PERIOD apart
    if (state_q != IDLE) begin
      per_d = per_q + 22'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = TRIG;
          per_d   = '0;
        end
      end
      TRIG: begin
        if (per_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
          // An echo already high here is stale; require a low before accepting a rise
          armed_d = ~echo_s;
        end
      end
      WAIT_ECHO: begin
        if (armed_q && echo_s) begin
          state_d = MEASURE;
          cnt_d   = 20'd1;
        end else begin
          if (!echo_s) begin
            armed_d = 1'b1;
          end
          if (cnt_q == WAIT_LAST) begin
            state_d = HOLDOFF;
            res_d   = NO_ECHO;
            to_d    = 1'b1;
            dv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_d = HOLDOFF;
          res_d   = cnt_q;
          to_d    = 1'b0;
          dv_d    = 1'b1;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = HOLDOFF;
          res_d   = NO_ECHO;
          to_d    = 1'b1;
          dv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      HOLDOFF: begin
        if (per_q == PER_LAST) begin
          if (bus.enable) begin
            state_d = TRIG;
            per_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.trig        = (state_q == TRIG);
  assign bus.busy        = (state_q != IDLE);
  assign bus.contador2   = res_q;
  assign bus.timeout     = to_q;
  assign bus.dato_valido = dv_q;

endmodule

// File: tb/tb_ultra_trigger.sv
// Directed bench for ultra_trigger with shortened timing parameters.
// Each shot is checked for trigger width, period spacing, reported width and timeout flag.
module tb_ultra_trigger;
  localparam int unsigned TC  = 10;
  localparam int unsigned EW  = 50;
  localparam int unsigned EM  = 200;
  localparam int unsigned PER = 400;

  logic clk = 1'b0;
  logic rst;

  ultra_trigger_if bus ();

  ultra_trigger #(
    .TRIG_CYCLES(TC),
    .ECHO_WAIT  (EW),
    .ECHO_MAX   (EM),
    .PERIOD     (PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          dv_seen  = 0;
  int          cap_cyc  = 0;
  logic [19:0] cap_val  = '0;
  logic        cap_to   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step; samples 1 time unit after the rising edge and latches any result strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.dato_valido === 1'b1) begin
      dv_seen++;
      cap_val = bus.contador2;
      cap_to  = bus.timeout;
      cap_cyc = cyc;
    end
  endtask

  // w=0: no echo. stale: echo held high across the trigger, dropped after gap, then a fresh pulse.
  task automatic do_shot(input string tag, input int w, input int gap,
                         input bit stale, input bit drop, output int rise);
    int          n;
    int          tf;
    logic [19:0] exp_val;
    logic        exp_to;
    n = 0;
    while (bus.trig !== 1'b1 && n < int'(PER) + 50) begin
      tick();
      n++;
    end
    chk({tag, " trig_rise"}, 32'(bus.trig), 32'd1);
    rise    = cyc;
    dv_seen = 0;
    if (stale) bus.echo = 1'b1;
    n = 0;
    while (bus.trig === 1'b1 && n < 2 * int'(TC)) begin
      tick();
      n++;
    end
    chk({tag, " trig_width"}, n, TC);
    tf = cyc;
    if (w > 0) begin
      repeat (gap) tick();
      if (stale) begin
        bus.echo = 1'b0;
        repeat (gap) tick();
      end
      bus.echo = 1'b1;
      for (int i = 0; i < w; i++) begin
        if (drop && i == w / 2) bus.enable = 1'b0;
        tick();
      end
      bus.echo = 1'b0;
    end
    n = 0;
    while (dv_seen == 0 && n < 2 * int'(EW)) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, " dv_pulses"}, dv_seen, 1);
    if (w == 0) chk({tag, " timeout_latency"}, cap_cyc - tf, EW);
    if (w == 0 || w > int'(EM)) begin
      exp_val = 20'hFFFFF;
      exp_to  = 1'b1;
    end else begin
      exp_val = 20'(w);
      exp_to  = 1'b0;
    end
    chk({tag, " contador2"}, 32'(cap_val), 32'(exp_val));
    chk({tag, " timeout"}, 32'(cap_to), 32'(exp_to));
    chk({tag, " held"}, 32'(bus.contador2), 32'(exp_val));
  endtask

  initial begin
    int ra, rb, rc, rx, n;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;
    repeat (3) tick();
    chk("rst trig", 32'(bus.trig), 32'd0);
    chk("rst contador2", 32'(bus.contador2), 32'd0);
    chk("rst dv", 32'(bus.dato_valido), 32'd0);
    chk("rst timeout", 32'(bus.timeout), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);

    rst        = 1'b0;
    bus.enable = 1'b1;
    do_shot("A", 37, 3, 1'b0, 1'b0, ra);
    chk("A busy", 32'(bus.busy), 32'd1);
    do_shot("B", 23, 3, 1'b0, 1'b0, rb);
    chk("period AB", rb - ra, PER);
    do_shot("C", 0, 0, 1'b0, 1'b0, rc);
    chk("period BC", rc - rb, PER);
    do_shot("D_max", int'(EM), 3, 1'b0, 1'b0, rx);
    do_shot("E_stuck", 300, 3, 1'b0, 1'b0, rx);
    do_shot("F_stale", 15, 5, 1'b1, 1'b0, rx);
    do_shot("G_drop", 19, 3, 1'b0, 1'b1, rx);

    n = 0;
    for (int i = 0; i < int'(PER) + 100; i++) begin
      tick();
      if (bus.trig === 1'b1) n++;
    end
    chk("idle no_trig", n, 0);
    chk("idle busy", 32'(bus.busy), 32'd0);
    chk("idle contador2", 32'(bus.contador2), 32'd19);

    bus.enable = 1'b1;
    n = 0;
    while (bus.trig !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("R trig_rise", 32'(bus.trig), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("R trig", 32'(bus.trig), 32'd0);
    chk("R busy", 32'(bus.busy), 32'd0);
    chk("R contador2", 32'(bus.contador2), 32'd0);
    chk("R timeout", 32'(bus.timeout), 32'd0);
    chk("R dv", 32'(bus.dato_valido), 32'd0);
    rst = 1'b0;
    do_shot("H", 50, 3, 1'b0, 1'b0, rx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ultra_trigger.md
ULTRA_TRIGGER -- requirements
Module: ultra_trigger

Interface
REQ-001 Parameter TRIG_CYCLES, default 500: trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter ECHO_WAIT, default 50000: max cycles from trig fall to echo rise (1 ms).
REQ-003 Parameter ECHO_MAX, default 1000000: max echo-high cycles counted before timeout (20 ms).
REQ-004 Parameter PERIOD, default 3000000: cycles between consecutive trigger rising edges (60 ms).
REQ-005 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  1 = run periodic measurements; 0 = stop after the current one.
REQ-008 echo  input  1  asynchronous echo line from sensor.
REQ-009 trig  output  1  trigger pulse to sensor.
REQ-010 contador2  output  20  last measured echo width in clk cycles; 20'hFFFFF = no echo/timeout.
REQ-011 dato_valido  output  1  one-cycle strobe when contador2 is updated.
REQ-012 timeout  output  1  1 when the last measurement timed out; updated with dato_valido.
REQ-013 busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 echo SHALL pass through a 2-flop synchronizer; all logic uses synchronized echo_s (2-cycle latency).
REQ-015 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-016 IDLE: trig=0; when enable=1, next cycle enters TRIG and clears the period counter to 0.
REQ-017 TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO with trig=0.
REQ-018 WAIT_ECHO: on echo_s=1 enter MEASURE with width counter=1; after ECHO_WAIT cycles without echo_s, complete with timeout.
REQ-019 MEASURE: width counter increments each cycle echo_s=1; on echo_s=0, contador2 := counter, timeout := 0, dato_valido=1 for one cycle, enter HOLDOFF.
REQ-020 MEASURE: if counter reaches ECHO_MAX with echo_s still 1, complete with timeout.
REQ-021 Timeout completion SHALL set contador2 := 20'hFFFFF, timeout := 1, dato_valido=1 for one cycle, enter HOLDOFF.
REQ-022 Width counter SHALL saturate, never wrap; contador2 holds its value between updates.
REQ-023 Period counter (22 bits) SHALL count every cycle from trig rise; HOLDOFF exits at count PERIOD-1.
REQ-024 HOLDOFF exit: enable=1 -> TRIG (next trig rise exactly PERIOD cycles after previous); enable=0 -> IDLE.
REQ-025 enable falling mid-measurement SHALL NOT abort; measurement completes and reports normally.
REQ-026 echo_s high on entry to WAIT_ECHO (stale echo) SHALL be ignored until a 0 is seen, then a fresh rise starts MEASURE.
REQ-027 Echo activity in IDLE, TRIG or HOLDOFF SHALL be ignored and SHALL NOT change contador2.
REQ-028 Parameters SHALL satisfy TRIG_CYCLES+ECHO_WAIT+ECHO_MAX+4 < PERIOD; HOLDOFF always reached before period end.

Reset
REQ-029 rst=1 at a clk edge SHALL force state IDLE, trig=0, contador2=0, dato_valido=0, timeout=0, busy=0, all counters and synchronizer flops 0.
REQ-030 rst asserted mid-TRIG or mid-MEASURE SHALL drop trig the next cycle with no dato_valido strobe; operation restarts from IDLE after rst=0.

Verification
REQ-031 enable=1, echo rises 100 cycles after trig fall, high 14750 cycles -> trig high exactly 500 cycles; contador2=14750, timeout=0, one dato_valido pulse.
REQ-032 enable=1, echo never rises -> dato_valido 50000 cycles after trig fall (+sync latency); contador2=20'hFFFFF, timeout=1.
REQ-033 enable=1 held, echo 2950 cycles each shot -> trig rising edges exactly 3000000 cycles apart; contador2=2950 each time.
REQ-034 echo stuck high for 1200000 cycles -> contador2=20'hFFFFF, timeout=1 after 1000000 counted cycles; no wrap.
REQ-035 enable dropped during MEASURE -> result reported, FSM returns to IDLE, no further trig; rst pulse during TRIG -> trig=0 next cycle, all outputs 0.
